// File: rtl/sdio_cmd_rx.sv
// SDIO CMD-line receiver: 48-bit frame capture, end-bit/CRC7 checks, error count.
// Optional CRC7 checking is enabled by defining SDIO_CMD_RX_CRC_CHECK_EN.
module sdio_cmd_rx #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 sd_clk,
  input  logic                 sd_resetn,
  input  logic                 sd_cmd,
  input  logic                 rx_en,
  output logic [47:0]          cmd_reg,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 rx_busy,
  output logic                 crc_err,
  output logic                 end_err,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                 state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [46:0]            sr_q, sr_d;
  logic                   done_q, done_d;
  logic [47:0]            reg_q, reg_d;
  logic                   vld_q, vld_d;
  logic                   end_err_q, end_err_d;
  logic                   ovr_q, ovr_d;
  logic [ERR_CNT_W-1:0]   ecnt_q, ecnt_d;
  logic                   end_bad, crc_bad, inc;

`ifdef SDIO_CMD_RX_CRC_CHECK_EN
  logic [6:0] crc_q, crc_d, crc_nxt;
  logic       crc_err_q, crc_err_d;
  logic       fb;

  assign fb      = sd_cmd ^ crc_q[6];
  assign crc_nxt = {crc_q[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  assign crc_bad = (sr_q[7:1] != crc_q);
  assign crc_err = crc_err_q;
`else
  assign crc_bad = 1'b0;
  assign crc_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    done_d  = 1'b0;
`ifdef SDIO_CMD_RX_CRC_CHECK_EN
    crc_d   = crc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rx_en && !sd_cmd) begin
          state_d = SHIFT;
          cnt_d   = 6'd46;
`ifdef SDIO_CMD_RX_CRC_CHECK_EN
          crc_d   = '0;
`endif
        end
      end
      SHIFT: begin
        if (!rx_en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          sr_d = {sr_q[45:0], sd_cmd};
`ifdef SDIO_CMD_RX_CRC_CHECK_EN
          if (cnt_q >= 6'd8) crc_d = crc_nxt;
`endif
          if (cnt_q == 6'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame verdict, one cycle after the end bit; host-bound frames are dropped
  always_comb begin
    reg_d     = reg_q;
    vld_d     = vld_q && !cmd_ready;
    end_err_d = 1'b0;
    ovr_d     = 1'b0;
    inc       = 1'b0;
    end_bad   = !sr_q[0];
`ifdef SDIO_CMD_RX_CRC_CHECK_EN
    crc_err_d = 1'b0;
`endif
    if (done_q && sr_q[46]) begin
      if (end_bad || crc_bad) begin
        end_err_d = end_bad;
`ifdef SDIO_CMD_RX_CRC_CHECK_EN
        crc_err_d = crc_bad;
`endif
        inc       = 1'b1;
      end else if (vld_q && !cmd_ready) begin
        ovr_d = 1'b1;
        inc   = 1'b1;
      end else begin
        reg_d = {1'b0, sr_q};
        vld_d = 1'b1;
      end
    end
    if (err_clr)
      ecnt_d = '0;
    else if (inc && !(&ecnt_q))
      ecnt_d = ecnt_q + ERR_CNT_W'(1);
    else
      ecnt_d = ecnt_q;
  end

  always_ff @(posedge sd_clk) begin
    if (!sd_resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      done_q    <= 1'b0;
      reg_q     <= '0;
      vld_q     <= 1'b0;
      end_err_q <= 1'b0;
      ovr_q     <= 1'b0;
      ecnt_q    <= '0;
`ifdef SDIO_CMD_RX_CRC_CHECK_EN
      crc_q     <= '0;
      crc_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      done_q    <= done_d;
      reg_q     <= reg_d;
      vld_q     <= vld_d;
      end_err_q <= end_err_d;
      ovr_q     <= ovr_d;
      ecnt_q    <= ecnt_d;
`ifdef SDIO_CMD_RX_CRC_CHECK_EN
      crc_q     <= crc_d;
      crc_err_q <= crc_err_d;
`endif
    end
  end

  assign cmd_reg   = reg_q;
  assign cmd_valid = vld_q;
  assign rx_busy   = (state_q == SHIFT);
  assign end_err   = end_err_q;
  assign overrun   = ovr_q;
  assign err_cnt   = ecnt_q;

endmodule

// File: tb/tb_sdio_cmd_rx.sv
// Scoreboard bench for sdio_cmd_rx: directed frames, queued expectations.
// A negedge monitor pops one expectation per delivery or error pulse.
module tb_sdio_cmd_rx;

  logic        clk;
  logic        sd_resetn, sd_cmd, rx_en, cmd_ready, err_clr;
  logic [47:0] cmd_reg, cmd_reg2;
  logic        cmd_valid, rx_busy, crc_err, end_err, overrun;
  logic        cmd_valid2, rx_busy2, crc_err2, end_err2, overrun2;
  logic [7:0]  err_cnt;
  logic [1:0]  err_cnt2;

  sdio_cmd_rx dut (
    .sd_clk(clk), .sd_resetn(sd_resetn), .sd_cmd(sd_cmd), .rx_en(rx_en),
    .cmd_reg(cmd_reg), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rx_busy(rx_busy), .crc_err(crc_err), .end_err(end_err),
    .overrun(overrun), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  sdio_cmd_rx #(.ERR_CNT_W(2)) dut2 (
    .sd_clk(clk), .sd_resetn(sd_resetn), .sd_cmd(sd_cmd), .rx_en(rx_en),
    .cmd_reg(cmd_reg2), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready),
    .rx_busy(rx_busy2), .crc_err(crc_err2), .end_err(end_err2),
    .overrun(overrun2), .err_clr(err_clr), .err_cnt(err_cnt2)
  );

  typedef struct {
    int          kind;
    logic [47:0] data;
    logic [2:0]  flags;
    int          cyc;
  } ev_t;

  localparam logic [47:0] CMD0     = 48'h400000000095;
  localparam logic [47:0] CMD0_E0  = 48'h400000000094;
  localparam logic [47:0] CMD8     = 48'h48000001AA87;
  localparam logic [47:0] CMD8_BAD = 48'h48000001AA89;
  localparam logic [47:0] CMD8_BB  = 48'h48000001AA88;
  localparam logic [47:0] DIR0     = 48'h0A1234567800;

  ev_t         sbq[$];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          exp_err = 0;
  logic        pv;
  logic [47:0] preg;
  logic [47:0] fr;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm);
    chk(nm, err_cnt, (exp_err > 255) ? 255 : exp_err);
    chk({nm, "_w2"}, err_cnt2, (exp_err > 3) ? 3 : exp_err);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sd_cmd = 1'b1;
    end
  endtask

  // kind: 0 no event, 1 delivery, 2 error pulses {crc,end,ovr}
  task automatic send(input logic [47:0] f, input int kind,
                      input logic [2:0] flg, input int abort_bit);
    ev_t e;
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      if (i == 47 && kind != 0) begin
        e.kind  = kind;
        e.data  = f;
        e.flags = flg;
        e.cyc   = cyc + 49;
        sbq.push_back(e);
      end
      if (i == abort_bit) begin
        chk("pre_abort_busy", rx_busy, 1);
        rx_en = 1'b0;
      end
      sd_cmd = f[i];
      if (i == abort_bit) begin
        @(posedge clk);
        #1;
        chk("abort_busy", rx_busy, 0);
      end
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    logic load, errev;
    if (!sd_resetn) begin
      pv   = 1'b0;
      preg = '0;
    end else begin
      load  = (cmd_valid && !pv) || (cmd_valid && pv && cmd_reg != preg);
      errev = crc_err || end_err || overrun;
      if (load || errev) begin
        if (sbq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_event: got load=%0b pulses=%b expected none",
                   load, {crc_err, end_err, overrun});
        end else begin
          e = sbq.pop_front();
          chk("ev_kind", load ? 1 : 2, e.kind);
          if (load)
            chk("ev_data", cmd_reg, e.data);
          else
            chk("ev_flags", {crc_err, end_err, overrun}, e.flags);
          chk("ev_cycle", cyc, e.cyc);
        end
      end
      pv   = cmd_valid;
      preg = cmd_reg;
    end
  end

  initial begin
    sd_resetn = 1'b0;
    sd_cmd    = 1'b0;
    rx_en     = 1'b1;
    cmd_ready = 1'b1;
    err_clr   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_reg", cmd_reg, 0);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_pulses", {crc_err, end_err, overrun}, 0);
    chk_cnt("rst_err_cnt");
    sd_cmd    = 1'b1;
    @(negedge clk);
    sd_resetn = 1'b1;
    idle(2);

    send(CMD0, 1, 3'b000, -1);
    idle(3);
    chk("cmd0_consumed", cmd_valid, 0);
    send(CMD8, 1, 3'b000, -1);
    idle(3);

`ifdef SDIO_CMD_RX_CRC_CHECK_EN
    send(CMD8_BAD, 2, 3'b100, -1);
    exp_err++;
`else
    send(CMD8_BAD, 1, 3'b000, -1);
`endif
    idle(3);
    chk_cnt("crc_bad_cnt");

    send(DIR0, 0, 3'b000, -1);
    idle(3);
    chk_cnt("dir0_cnt");

    send(CMD0_E0, 2, 3'b010, -1);
    exp_err++;
    idle(3);
    chk_cnt("end0_cnt");

`ifdef SDIO_CMD_RX_CRC_CHECK_EN
    send(CMD8_BB, 2, 3'b110, -1);
`else
    send(CMD8_BB, 2, 3'b010, -1);
`endif
    exp_err++;
    idle(3);
    chk_cnt("both_cnt");

    cmd_ready = 1'b0;
    send(CMD8, 1, 3'b000, -1);
    send(CMD0, 2, 3'b001, -1);
    exp_err++;
    idle(3);
    chk("ovr_hold_reg", cmd_reg, CMD8);
    chk("ovr_hold_valid", cmd_valid, 1);
    chk_cnt("ovr_cnt");

    send(CMD0, 1, 3'b000, -1);
    @(negedge clk);
    sd_cmd    = 1'b1;
    cmd_ready = 1'b1;
    idle(3);
    chk("ready_load_drained", cmd_valid, 0);
    chk("ready_load_reg", cmd_reg, CMD0);
    chk_cnt("ready_load_cnt");

    send(CMD0, 0, 3'b000, 20);
    idle(3);
    chk("abort_valid", cmd_valid, 0);
    @(negedge clk);
    rx_en = 1'b1;
    idle(2);
    send(CMD0, 1, 3'b000, -1);
    idle(3);

    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 0;
    idle(1);
    chk_cnt("clr_cnt");

    for (int k = 0; k < 5; k++) begin
      send(CMD0_E0, 2, 3'b010, -1);
      exp_err++;
    end
    idle(3);
    chk_cnt("sat_cnt");

    send(CMD0_E0, 2, 3'b010, -1);
    @(negedge clk);
    sd_cmd  = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 0;
    idle(2);
    chk_cnt("clr_wins_cnt");

    fr = CMD8;
    for (int i = 47; i >= 27; i--) begin
      @(negedge clk);
      sd_cmd = fr[i];
    end
    @(negedge clk);
    chk("mid_busy", rx_busy, 1);
    sd_resetn = 1'b0;
    sd_cmd    = 1'b1;
    @(negedge clk);
    sd_resetn = 1'b1;
    chk("mid_rst_busy", rx_busy, 0);
    idle(30);
    chk("mid_rst_quiet", rx_busy, 0);
    chk("mid_rst_valid", cmd_valid, 0);
    send(CMD0, 1, 3'b000, -1);
    idle(5);
    chk_cnt("final_cnt");
    chk("sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
